// File: rtl/div_pkg.sv
// Shared types and widths for the sequential 16/8 unsigned divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int PREM_W     = DIVIDEND_W + 1;
  localparam int CNT_W      = 5;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [PREM_W-1:0]    prem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [PREM_W-1:0]    prem_o,
  output logic                 qbit_o
);

  logic [PREM_W-1:0] shifted;
  logic [PREM_W-1:0] divisor_ext;

  always_comb begin
    shifted     = {prem_i[PREM_W-2:0], bit_i};
    divisor_ext = {{(PREM_W-DIVISOR_W){1'b0}}, divisor_i};
    // The top bit only matters as a carry-out of the shift; if set, the subtract always succeeds.
    qbit_o      = prem_i[PREM_W-1] | (shifted >= divisor_ext);
    prem_o      = qbit_o ? (shifted - divisor_ext) : shifted;
  end

endmodule

// File: rtl/unsigned_16x8_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// DIV_APPROX_EN: drop the TRUNC low dividend bits and run TRUNC fewer iterations.
module unsigned_16x8_div_seq
  import div_pkg::*;
#(
  parameter int TRUNC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] x,
  input  logic [DIVISOR_W-1:0]  y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  div_by_zero
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its data until that edge, the consumer may change ready freely.

`ifdef DIV_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  localparam int SHIFT = APPROX ? TRUNC : 0;
  localparam int STEPS = DIVIDEND_W - SHIFT;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dsr_q;
  logic [PREM_W-1:0]     prem_q;
  logic [DIVIDEND_W-1:0] q_q;
  logic [DIVISOR_W-1:0]  r_q;
  logic                  dbz_q;
  logic                  out_valid_q;

  logic [PREM_W-1:0]     prem_d;
  logic                  qbit;
  logic [DIVIDEND_W-1:0] dvd_d;
  logic [DIVIDEND_W-1:0] q_d;

  div_step u_step (
    .prem_i    (prem_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dsr_q),
    .prem_o    (prem_d),
    .qbit_o    (qbit)
  );

  // Quotient bits fill the dividend register from the bottom as dividend bits leave the top.
  always_comb begin
    dvd_d = {dvd_q[DIVIDEND_W-2:0], qbit};
    q_d   = dvd_d << SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      prem_q      <= '0;
      q_q         <= '0;
      r_q         <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (y == '0) begin
              state_q     <= DONE;
              q_q         <= '1;
              r_q         <= x[DIVISOR_W-1:0];
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= CALC;
              dvd_q   <= x;
              dsr_q   <= y;
              prem_q  <= '0;
              cnt_q   <= LAST_CNT;
            end
          end
        end
        CALC: begin
          dvd_q  <= dvd_d;
          prem_q <= prem_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            q_q         <= q_d;
            r_q         <= prem_d[DIVISOR_W-1:0];
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule
